// File: rtl/sramlike_arbiter_pkg.sv
// Shared types and widths for the two-to-one SRAM-like bus arbiter.
package sramlike_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SIZE_W = 2;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/sramlike_arbiter.sv
// Shares one SRAM-like bus between fetch and mem ports, one transaction in flight,
// data-first priority with a bounded streak so fetch cannot starve.
module sramlike_arbiter
  import sramlike_arbiter_pkg::*;
#(
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [SIZE_W-1:0] inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,

  input  logic              data_req,
  input  logic              data_wr,
  input  logic [SIZE_W-1:0] data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,

  output logic              bus_req,
  output logic              bus_wr,
  output logic [SIZE_W-1:0] bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata
);

  localparam int unsigned STREAK_W = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  arb_state_t           state_q, state_d;
  arb_owner_t           owner_q, owner_d;
  logic [STREAK_W-1:0]  streak_q, streak_d;
  logic                 grant_inst;
  logic                 grant_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      owner_q  <= OWN_INST;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
    end
  end

  // Fetch wins only when data is absent or has used up its streak allowance.
  always_comb begin
    grant_inst = inst_req && (!data_req || (streak_q >= STREAK_MAX));
    grant_data = !grant_inst && data_req;
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    streak_d     = streak_q;
    bus_req      = 1'b0;
    bus_wr       = 1'b0;
    bus_size     = '0;
    bus_addr     = '0;
    bus_wdata    = '0;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = '0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = '0;

    // Everything stays quiet while reset is held.
    if (!rst) begin
      inst_rdata = bus_rdata;
      data_rdata = bus_rdata;
      unique case (state_q)
        ARB_IDLE: begin
          if (grant_inst) begin
            bus_req      = 1'b1;
            bus_wr       = inst_wr;
            bus_size     = inst_size;
            bus_addr     = inst_addr;
            bus_wdata    = inst_wdata;
            inst_addr_ok = bus_addr_ok;
          end else if (grant_data) begin
            bus_req      = 1'b1;
            bus_wr       = data_wr;
            bus_size     = data_size;
            bus_addr     = data_addr;
            bus_wdata    = data_wdata;
            data_addr_ok = bus_addr_ok;
          end
          if (bus_addr_ok && bus_req) begin
            state_d = ARB_BUSY;
            if (grant_inst) begin
              owner_d  = OWN_INST;
              streak_d = '0;
            end else begin
              owner_d = OWN_DATA;
              if (inst_req) begin
                streak_d = (streak_q < STREAK_MAX) ? streak_q + STREAK_W'(1) : streak_q;
              end else begin
                streak_d = '0;
              end
            end
          end
        end
        ARB_BUSY: begin
          if (owner_q == OWN_INST) begin
            inst_data_ok = bus_data_ok;
          end else begin
            data_data_ok = bus_data_ok;
          end
          if (bus_data_ok) begin
            state_d = ARB_IDLE;
          end
        end
        default: state_d = ARB_IDLE;
      endcase
    end
  end

endmodule
